// File: rtl/bus_sync_pkg.sv
// Shared types and constants for the multi-bit quasi-static bus crossing.
// Used by the source-side launcher and the destination-side sampler.
package bus_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_WAIT_ECHO = 2'd2
    } bus_launch_state_t;

    // Consecutive equal samples the receiver needs before it trusts the bus.
    localparam int BUS_SYNC_MIN_EQ_SAMPLES = 2;

endpackage

// File: rtl/bus_launch_a_if.sv
// Word handshake into the launcher plus the registered crossing bus it drives.
// Signal names follow the launcher's point of view (i_* into it, o_* out of it).
interface bus_launch_a_if #(
    parameter int BUS_WIDTH = 1
);
    logic [BUS_WIDTH-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic [BUS_WIDTH-1:0] o_data_a;
    logic                 o_busy;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_data_a,
        input  o_busy
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_data_a,
        output o_busy
    );
endinterface

// File: rtl/cov_core_bits_sync.sv
// Plain DEPTH-stage retiming chain for an asynchronous multi-bit input.
// Latency DEPTH cycles; no backpressure, samples every cycle.
module cov_core_bits_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_bits,
    output logic [WIDTH-1:0] o_bits
);
    logic [DEPTH-1:0][WIDTH-1:0] sync_q;
    logic [DEPTH-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = i_bits;
        for (int i = 1; i < DEPTH; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_bits = sync_q[DEPTH-1];
endmodule

// File: rtl/bus_launch_a.sv
// Launches a word onto the quasi-static crossing bus and holds it HOLD_CYCLES; o_ready low N..N+HOLD_CYCLES.
// BUS_LAUNCH_ECHO_EN adds i_echo_b: release additionally waits for two consecutive retimed echo matches.
module bus_launch_a
    import bus_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = 1,
    parameter int NUM_RETIME  = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                 i_clk_a,
    input  logic                 i_rst_a_n,
`ifdef BUS_LAUNCH_ECHO_EN
    input  logic [BUS_WIDTH-1:0] i_echo_b,
`endif
    bus_launch_a_if.slave        bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    generate
        if (HOLD_CYCLES < NUM_RETIME + BUS_SYNC_MIN_EQ_SAMPLES) begin : g_bad_hold
            $error("bus_launch_a: HOLD_CYCLES must be >= NUM_RETIME+2");
        end
    endgenerate

    bus_launch_state_t    state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 xfer;

`ifdef BUS_LAUNCH_ECHO_EN
    logic [BUS_WIDTH-1:0] echo_sync;
    logic                 match_q, match_d;
    logic                 prev_q, prev_d;

    cov_core_bits_sync #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (NUM_RETIME)
    ) u_echo_sync (
        .i_clk   (i_clk_a),
        .i_rst_n (i_rst_a_n),
        .i_bits  (i_echo_b),
        .o_bits  (echo_sync)
    );

    // prev_q only accumulates while waiting, so stale matches from an older word never count.
    always_comb begin
        match_d = (echo_sync == data_q);
        prev_d  = (state_q == ST_WAIT_ECHO) ? match_q : 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        xfer    = bus.i_valid && rdy_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    data_d  = bus.i_data;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
`ifdef BUS_LAUNCH_ECHO_EN
                    state_d = ST_WAIT_ECHO;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef BUS_LAUNCH_ECHO_EN
            ST_WAIT_ECHO: begin
                if (match_q && prev_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Ready is registered from next state so it never depends on i_valid combinationally.
        rdy_d  = (state_d == ST_IDLE);
        busy_d = !rdy_d;
    end

    always_ff @(posedge i_clk_a) begin
        if (!i_rst_a_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BUS_LAUNCH_ECHO_EN
            match_q <= 1'b0;
            prev_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
`ifdef BUS_LAUNCH_ECHO_EN
            match_q <= match_d;
            prev_q  <= prev_d;
`endif
        end
    end

    assign bus.o_ready  = rdy_q;
    assign bus.o_data_a = data_q;
    assign bus.o_busy   = busy_q;
endmodule

// File: tb/tb_bus_launch_a.sv
// Self-checking bench for bus_launch_a: directed table, corner sequences, random run against a model.
module tb_bus_launch_a;
    import bus_sync_pkg::*;

    localparam int W = 8;
    localparam int H = 8;
    localparam int R = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    bus_launch_a_if #(.BUS_WIDTH(W)) bus ();
`ifdef BUS_LAUNCH_ECHO_EN
    logic [W-1:0] echo_b;
    logic [W-1:0] dly [5];
    bit           echo_track;
`endif

    bus_launch_a #(
        .BUS_WIDTH   (W),
        .NUM_RETIME  (R),
        .HOLD_CYCLES (H)
    ) dut (
        .i_clk_a   (clk),
        .i_rst_a_n (rst_n),
`ifdef BUS_LAUNCH_ECHO_EN
        .i_echo_b  (echo_b),
`endif
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Model: a launch at edge e makes the launcher free again from edge e+H onward.
    logic [W-1:0] m_data = '0;
    logic         m_rdy  = 1'b0;
    logic         m_busy = 1'b0;
    int           m_rel  = 0;
    bit           chk_model = 1'b0;

    typedef struct {
        logic         rst_n;
        logic         vld;
        logic [W-1:0] dat;
        logic         exp_rdy;
        logic [W-1:0] exp_dat;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        logic pre_rdy;
        @(posedge clk);
        edge_n++;
        pre_rdy = m_rdy;
        if (!rst_n) begin
            m_data = '0;
            m_rdy  = 1'b0;
            m_busy = 1'b0;
            m_rel  = 0;
        end else begin
            if (bus.i_valid && pre_rdy) begin
                m_data = bus.i_data;
                m_rel  = edge_n + H;
            end
            m_rdy  = (edge_n >= m_rel);
            m_busy = !m_rdy;
        end
        #1;
`ifdef BUS_LAUNCH_ECHO_EN
        if (echo_track) begin
            for (int i = 4; i > 0; i--) dly[i] = dly[i-1];
            dly[0] = bus.o_data_a;
            echo_b = dly[4];
        end
`endif
        if (chk_model) begin
            chk("model_ready", bus.o_ready, m_rdy);
            chk("model_busy", bus.o_busy, m_busy);
            chk("model_data", bus.o_data_a, m_data);
        end
    endtask

    // Waits for ready, launches d, returns the number of edges until ready again (-1 on timeout).
    task automatic launch(input logic [W-1:0] d, output int hold_edges);
        int n;
        n = 0;
        while (!bus.o_ready && n < 60) begin
            step();
            n++;
        end
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        step();
        bus.i_valid = 1'b0;
        hold_edges = 0;
        while (!bus.o_ready && hold_edges < 60) begin
            step();
            hold_edges++;
        end
        if (!bus.o_ready) begin
            chk("launch_timeout", 32'd0, 32'd1);
            hold_edges = -1;
        end
    endtask

    function automatic vec_t mk(logic r, logic v, logic [W-1:0] d, logic er, logic [W-1:0] ed);
        vec_t t;
        t.rst_n = r; t.vld = v; t.dat = d; t.exp_rdy = er; t.exp_dat = ed;
        return t;
    endfunction

    initial begin
        int hold_a, hold_b, seen;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
`ifdef BUS_LAUNCH_ECHO_EN
        echo_b     = '0;
        echo_track = 1'b0;
        for (int i = 0; i < 5; i++) dly[i] = '0;
`endif

`ifndef BUS_LAUNCH_ECHO_EN
        // Edges 1..3 reset, 4 release, A5 at 10 with busy-time noise, 3C back-to-back at 19.
        for (int e = 1; e <= 3; e++) tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        for (int e = 4; e <= 9; e++) tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, 8'hA5, 1'b0, 8'hA5));
        for (int e = 11; e <= 17; e++) tbl.push_back(mk(1'b1, 1'b1, 8'(e * 7), 1'b0, 8'hA5));
        tbl.push_back(mk(1'b1, 1'b1, 8'h77, 1'b1, 8'hA5));
        tbl.push_back(mk(1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C));
        for (int e = 20; e <= 26; e++) tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h3C));
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h3C));

        foreach (tbl[i]) begin
            rst_n       = tbl[i].rst_n;
            bus.i_valid = tbl[i].vld;
            bus.i_data  = tbl[i].dat;
            step();
            chk("tbl_ready", bus.o_ready, tbl[i].exp_rdy);
            chk("tbl_busy", bus.o_busy, tbl[i].rst_n ? !tbl[i].exp_rdy : 1'b0);
            chk("tbl_data", bus.o_data_a, tbl[i].exp_dat);
        end
        bus.i_valid = 1'b0;
        chk_model   = 1'b1;

        // Reset three cycles into a hold of FF abandons it.
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hFF;
        step();
        bus.i_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_data", bus.o_data_a, 32'h0);
        chk("rst_mid_state", dut.state_q, ST_IDLE);
        rst_n = 1'b1;
        step();
        launch(8'h42, hold_a);
        chk("post_rst_launch", hold_a, H);

        // Same value twice: two full holds, bus constant (model checks every edge).
        launch(8'h11, hold_a);
        launch(8'h11, hold_b);
        chk("relaunch_hold_1", hold_a, H);
        chk("relaunch_hold_2", hold_b, H);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst_n       = ($urandom_range(0, 79) != 0);
            bus.i_valid = $urandom_range(0, 1);
            bus.i_data  = 8'($urandom);
            step();
        end
`else
        repeat (3) step();
        chk("echo_rst_ready", bus.o_ready, 32'h0);
        rst_n = 1'b1;
        step();
        chk("echo_rel_ready", bus.o_ready, 32'h1);

        // Echo tracks the bus with a 5-cycle delay: release no earlier than N+H+2.
        echo_track = 1'b1;
        launch(8'h5A, hold_a);
        chk("echo_rel_min", (hold_a >= H + 2), 32'h1);
        chk("echo_rel_max", (hold_a <= H + 8), 32'h1);

        // Echo stuck at 00: never released.
        echo_track  = 1'b0;
        echo_b      = '0;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hC3;
        step();
        bus.i_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.o_ready) seen++;
        end
        chk("echo_stale_ready", seen, 0);
        chk("echo_stale_data", bus.o_data_a, 32'hC3);
        rst_n = 1'b0;
        step();
        chk("echo_rst_data", bus.o_data_a, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
